// File: rtl/rr_mux4_1.sv
// Four-lane round-robin merger onto one registered valid/ready output lane.
// Each beat carries its 2-bit source lane code for the downstream demultiplexer.
module rr_mux4_1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic [WIDTH-1:0] id0,
  input  logic [WIDTH-1:0] id1,
  input  logic [WIDTH-1:0] id2,
  input  logic [WIDTH-1:0] id3,
  input  logic             iv0,
  input  logic             iv1,
  input  logic             iv2,
  input  logic             iv3,
  output logic             or0,
  output logic             or1,
  output logic             or2,
  output logic             or3,
  output logic [WIDTH-1:0] odata,
  output logic             os1,
  output logic             os0,
  output logic             ov,
  input  logic             ir
);

  logic [WIDTH-1:0] id_arr [4];
  logic [3:0]       iv_vec;
  logic [3:0]       rdy_vec;

  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       src_q, src_d;
  logic             ov_q, ov_d;
  logic [1:0]       last_q, last_d;

  logic [1:0]       grant;
  logic             grant_vld;
  logic [1:0]       cand;
  logic             can_load;
  logic             load;

  assign id_arr[0] = id0;
  assign id_arr[1] = id1;
  assign id_arr[2] = id2;
  assign id_arr[3] = id3;
  assign iv_vec    = {iv3, iv2, iv1, iv0};

  // Scan from farthest to nearest so the lane closest after last_q wins.
  always_comb begin
    grant     = last_q;
    grant_vld = 1'b0;
    cand      = last_q;
    for (int i = 4; i >= 1; i--) begin
      cand = last_q + 2'(i);
      if (iv_vec[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
  end

  assign can_load = !ov_q || ir;
  assign load     = can_load && grant_vld && !irst;
  assign rdy_vec  = load ? (4'b0001 << grant) : 4'b0000;

  always_comb begin
    data_d = data_q;
    src_d  = src_q;
    ov_d   = ov_q;
    last_d = last_q;
    if (load) begin
      data_d = id_arr[grant];
      src_d  = grant;
      ov_d   = 1'b1;
      last_d = grant;
    end else if (ir) begin
      // Drain without reload: data and source are left stale.
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      data_q <= '0;
      src_q  <= 2'b00;
      ov_q   <= 1'b0;
      last_q <= 2'b11;
    end else begin
      data_q <= data_d;
      src_q  <= src_d;
      ov_q   <= ov_d;
      last_q <= last_d;
    end
  end

  assign or0   = rdy_vec[0];
  assign or1   = rdy_vec[1];
  assign or2   = rdy_vec[2];
  assign or3   = rdy_vec[3];
  assign odata = data_q;
  assign os1   = src_q[1];
  assign os0   = src_q[0];
  assign ov    = ov_q;

endmodule

// File: doc/rr_mux4_1.md
# rr_mux4_1

Four-lane round-robin merger: takes up to four valid/ready input lanes and serialises them onto one registered output lane. Each output beat carries the 2-bit source code {os1,os0}, which drives the select inputs of the downstream 1-to-4 demultiplexer so that each beat returns to its lane of origin. It sits upstream of that demultiplexer on the shared link and provides fair arbitration with full-throughput backpressure.

## Interface
- WIDTH, 8, data width of every lane
- iclk  input  1  clock; all state updates on rising edge
- irst  input  1  reset, asynchronous, active-high
- id0..id3  input  WIDTH each  lane k data
- iv0..iv3  input  1 each  lane k valid
- or0..or3  output  1 each  lane k ready (combinational)
- odata  output  WIDTH  merged data (registered)
- os1, os0  output  1 each  source lane code of odata, {os1,os0} = k (registered)
- ov  output  1  odata/os valid (registered)
- ir  input  1  downstream ready

## Operation
- State:
  - output register {odata, os1, os0, ov}
  - 2-bit priority pointer `last` (last granted lane)
- can_load = !ov || ir; the output register is empty, or drains this cycle.
- Grant search: scan lanes in order last+1, last+2, last+3, last (mod 4); the grant goes to the first lane with iv_k = 1. The search is purely combinational from iv0..iv3 and `last`.
- Ready: or_k = can_load && (grant == k) && iv_k. At most one or_k is high in any cycle. or_k = 0 for non-granted lanes even when they are valid.
- Input transfer on lane k: iv_k && or_k. The same edge loads:
  - odata <= id_k
  - {os1,os0} <= k
  - ov <= 1
  - last <= k
- Output transfer: ov && ir.
  - If it coincides with an input transfer, the register reloads. ov stays 1.
  - Otherwise ov <= 0. odata and os hold their stale values.
- ov && !ir: odata, os, ov and `last` all hold. All or_k are 0.
- An upstream lane must hold id_k stable while iv_k=1 && or_k=0. iv_k may deassert only after a transfer. The block does not check this rule.
- `last` changes only on an input transfer. Idle cycles never move the priority.
- Reset (asserted at any time, including mid-transfer):
  - ov=0, odata=0, {os1,os0}=2'b00, last=2'b11 (so lane 0 has first priority)
  - or0..or3 forced to 0 while irst=1
  - A beat in flight in the output register is discarded. It is not replayed.

## Timing
- Latency: input transfer at edge N gives ov=1 with that data during cycle N+1 (one cycle).
- Throughput: one beat per cycle when ir=1 continuously, independent of how many lanes are active.
- Fairness: with all four lanes continuously valid and ir=1, the grant order is 0,1,2,3,0,… For any lane, the wait between its own grants is at most 3 grants.
- The ready path is combinational: iv_k → or_k through the arbiter, and ir → or_k through can_load. There is no combinational path from any input to odata, os or ov.
- The release of irst is synchronous to iclk at the system level. The first transfer is possible on the first rising edge after release.

## Test plan
- Reset: assert irst mid-stream with ov=1 and odata=8'hA5 → ov=0, odata=8'h00, {os1,os0}=00, all or_k=0 immediately (no clock edge needed). After release with all iv=1, the first beat comes from lane 0.
- Single lane: iv2=1 with id2=8'h3C, ir=1 → or2=1. The next cycle shows ov=1, odata=8'h3C, {os1,os0}=10. Held continuously with changing data, the output carries back-to-back beats from lane 2 every cycle.
- Full contention: iv0..iv3=1, id_k=8'h10+k, ir=1 for 8 cycles → odata sequence 10,11,12,13,10,11,12,13, with {os1,os0} matching the low two bits.
- Backpressure: ov=1 (odata=8'h11, os=01), ir=0 for 3 cycles with iv0, iv2 high → odata/os/ov stable and all or_k=0 for those 3 cycles. When ir rises, the next grant is lane 2 (pointer at 1), then lane 0.
- Drain and idle: one beat on lane 3 with ir=1, then all iv=0 → ov goes 1 for exactly one cycle, then 0, with `last`=3. A later iv0 and iv1 together → lane 0 granted first.
- Pointer skip: last=0, only iv3=1 → lane 3 granted without idle cycles. Then iv1 and iv3 → lane 1 granted first (scan order 0,1,2,3 from last=3).
